n64_sync_gen: RTL and testbench
===============================

Name: n64_sync_gen

Overview:
- Generates N64-style video bus timing: the nDSYNC cadence and the 4-bit sync vector {nVSYNC,nCLAMP,nHSYNC,nCSYNC}.
- Timing covers NTSC/PAL in progressive (240p/288p) or interlaced (480i/576i) mode.
- Acts as the transmitter counterpart of the vinfo extractor. Used as the on-board test-pattern/timing source and as the loopback stimulus for the receive path.
- Its output fed to the extractor must reproduce the requested {palmode,n64_480i}.

Parameters:
- H_TOTAL_NTSC, 773, pixel ticks per line in NTSC.
- H_TOTAL_PAL, 794, pixel ticks per line in PAL.
- HSYNC_LEN, 57, ticks nHSYNC is low at line start.
- CLAMP_LEN, 20, ticks nCLAMP is low, starting right after nHSYNC rises.
- VSYNC_LINES, 3, lines nVSYNC is low per field.

Ports:
- VCLK  input  1  video clock
- RST  input  1  synchronous reset, active high
- vinfo_i  input  2  requested mode {palmode,n64_480i}; 1 = PAL / interlaced
- nDSYNC  output  1  low for 1 VCLK out of every 4; marks the sync slot
- Sync_o  output  4  {nVSYNC,nCLAMP,nHSYNC,nCSYNC}, all active low
- field_o  output  1  0 = field A (vsync at line start), 1 = field B (vsync at half line)
- vinfo_o  output  2  mode currently being generated, {palmode,n64_480i}

Behaviour:
- Reset: synchronous, active high. Interface is one clock; reset is synchronous and active-high.
  - Reset values: ph=0, hcnt=0, vcnt=0, nDSYNC=1, Sync_o=4'b1111, field_o=0.
  - vinfo_o loads vinfo_i every cycle while RST=1.
  - Reset asserted mid-frame aborts the frame immediately. No partial sync pulse is held.
- Phase counter ph (2 bit) increments every VCLK and wraps 3->0.
  - nDSYNC is registered: low in the cycle after ph==3, i.e. once every 4 VCLK.
  - First nDSYNC low occurs 4 VCLK after RST deasserts.
- Pixel tick = the VCLK edge that drives nDSYNC low.
  - hcnt, vcnt and Sync_o update only on pixel ticks, then hold for 4 VCLK.
  - Sync_o is therefore stable while nDSYNC is low.
- Horizontal counter hcnt (10 bit): counts 0..H_TOTAL-1 (H_TOTAL per vinfo_o[1]), then wraps to 0 and increments vcnt.
  - H_HALF = H_TOTAL>>1.
- Line count L per frame:
  - NTSC: 263 progressive, 525 interlaced.
  - PAL: 313 progressive, 625 interlaced.
  - vcnt (10 bit) wraps from L-1 to 0.
- Mode change: vinfo_i is sampled into vinfo_o only at the last tick of a frame (vcnt=L-1, hcnt=H_TOTAL-1). The new mode takes effect at the next frame start. A mid-frame change of vinfo_i has no effect until then.
- nHSYNC: low for hcnt in [0,HSYNC_LEN-1], every line including vsync lines.
- nCLAMP: low for hcnt in [HSYNC_LEN, HSYNC_LEN+CLAMP_LEN-1], only while nVSYNC=1.
- nVSYNC, field A: low from (vcnt=0,hcnt=0) up to, excluding, (vcnt=VSYNC_LINES,hcnt=0).
- nVSYNC, field B (interlaced only): low from (vcnt=Lh,hcnt=H_HALF) up to, excluding, (vcnt=Lh+VSYNC_LINES,hcnt=H_HALF).
  - Lh = 262 for NTSC, 312 for PAL.
- Progressive mode: field B never occurs. field_o stays 0.
- field_o: goes to 1 on the tick where field-B nVSYNC falls. Returns to 0 at vcnt=0,hcnt=0.
- nCSYNC = nHSYNC XNOR nVSYNC (inverted hsync during vsync, i.e. serration).
- Guaranteed receiver view (hsync falls counted between consecutive nVSYNC falls, excluding a coincident one):
  - NTSC: 262 -> count mod 4 = 2 -> palmode 0.
  - PAL: 312 -> count mod 4 = 0 -> palmode 1.
  - Progressive: vsync always coincides with a hsync fall.
  - Interlaced: coincidence alternates field to field.

Test Plan:
- RST high 10 VCLK, then low, vinfo_i=00 -> nDSYNC first low 4 VCLK later, then period 4. Sync_o=1111 during reset. First tick shows nVSYNC=0, nHSYNC=0, nCSYNC=1.
- vinfo_i=00, run 2 frames -> 773 ticks per line, nHSYNC low 57 ticks, nVSYNC fall period 263*773 ticks, field_o always 0.
- vinfo_i=01 -> nVSYNC falls alternate at hcnt=0 and hcnt=386. field_o toggles. Field lengths 262.5 lines each.
- Loopback into the vinfo extractor for each vinfo_i of 00,01,10,11 -> extractor vinfo_o equals vinfo_i by the third field.
- Change vinfo_i 00->10 mid-frame -> vinfo_o and H_TOTAL remain NTSC until the frame's last tick. Next frame uses 794 ticks and 313 lines.
- Assert RST for 1 VCLK at vcnt=100 -> next cycle all outputs at reset values. Timing restarts from vcnt=0,hcnt=0.

Source files
------------

// File: rtl/n64_sync_gen.sv
// rtl/n64_sync_gen.sv - N64 video bus timing source: nDSYNC cadence and {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
// Frame height is derived from the half-frame line count: progressive L=LH+1, interlaced L=2*LH+1.
module n64_sync_gen #(
    parameter int H_TOTAL_NTSC = 773,
    parameter int H_TOTAL_PAL  = 794,
    parameter int HSYNC_LEN    = 57,
    parameter int CLAMP_LEN    = 20,
    parameter int VSYNC_LINES  = 3,
    parameter int LH_NTSC      = 262,
    parameter int LH_PAL       = 312
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic [1:0] vinfo_i,
    output logic       nDSYNC,
    output logic [3:0] Sync_o,
    output logic       field_o,
    output logic [1:0] vinfo_o
);

    localparam logic [9:0] HT_N   = 10'(H_TOTAL_NTSC);
    localparam logic [9:0] HT_P   = 10'(H_TOTAL_PAL);
    localparam logic [9:0] HS_W   = 10'(HSYNC_LEN);
    localparam logic [9:0] CL_END = 10'(HSYNC_LEN + CLAMP_LEN);
    localparam logic [9:0] VS_W   = 10'(VSYNC_LINES);
    localparam logic [9:0] LH_N   = 10'(LH_NTSC);
    localparam logic [9:0] LH_P   = 10'(LH_PAL);

    logic [1:0] ph_q, ph_d;
    logic       ndsync_q, ndsync_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [3:0] sync_q, sync_d;
    logic       field_q, field_d;
    logic [1:0] vinfo_q, vinfo_d;

    logic       tick;
    logic [9:0] h_total, h_half, lh, v_last;
    logic       h_last, vs_a, vs_b, n_v, n_h, n_cl, n_cs;

    always_comb begin
        tick    = (ph_q == 2'd3);
        h_total = vinfo_q[1] ? HT_P : HT_N;
        h_half  = h_total >> 1;
        lh      = vinfo_q[1] ? LH_P : LH_N;
        v_last  = vinfo_q[0] ? {lh[8:0], 1'b0} : lh;
        h_last  = (hcnt_q == h_total - 10'd1);

        // Field B vsync spans from mid-line Lh to mid-line Lh+VSYNC_LINES.
        vs_a = (vcnt_q < VS_W);
        vs_b = vinfo_q[0] &&
               (((vcnt_q == lh) && (hcnt_q >= h_half)) ||
                ((vcnt_q > lh) && (vcnt_q < lh + VS_W)) ||
                ((vcnt_q == lh + VS_W) && (hcnt_q < h_half)));
        n_v  = ~(vs_a | vs_b);
        n_h  = ~(hcnt_q < HS_W);
        n_cl = ~(n_v && (hcnt_q >= HS_W) && (hcnt_q < CL_END));
        n_cs = ~(n_h ^ n_v);

        ph_d     = ph_q + 2'd1;
        ndsync_d = ~tick;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        sync_d   = sync_q;
        field_d  = field_q;
        vinfo_d  = vinfo_q;

        if (tick) begin
            sync_d = {n_v, n_cl, n_h, n_cs};
            if ((vcnt_q == 10'd0) && (hcnt_q == 10'd0)) begin
                field_d = 1'b0;
            end else if (vinfo_q[0] && (vcnt_q == lh) && (hcnt_q == h_half)) begin
                field_d = 1'b1;
            end
            if (h_last) begin
                hcnt_d = 10'd0;
                if (vcnt_q == v_last) begin
                    vcnt_d  = 10'd0;
                    vinfo_d = vinfo_i;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            ph_q     <= 2'd0;
            ndsync_q <= 1'b1;
            hcnt_q   <= 10'd0;
            vcnt_q   <= 10'd0;
            sync_q   <= 4'b1111;
            field_q  <= 1'b0;
            vinfo_q  <= vinfo_i;
        end else begin
            ph_q     <= ph_d;
            ndsync_q <= ndsync_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            sync_q   <= sync_d;
            field_q  <= field_d;
            vinfo_q  <= vinfo_d;
        end
    end

    assign nDSYNC  = ndsync_q;
    assign Sync_o  = sync_q;
    assign field_o = field_q;
    assign vinfo_o = vinfo_q;

endmodule

// File: tb/tb_n64_sync_gen.sv
// tb/tb_n64_sync_gen.sv - randomized self-checking bench for n64_sync_gen against a frame-position model
module tb_n64_sync_gen;

    localparam int HN  = 21;
    localparam int HP  = 22;
    localparam int HS  = 5;
    localparam int CL  = 3;
    localparam int VS  = 2;
    localparam int LHN = 10;
    localparam int LHP = 12;

    logic       VCLK;
    logic       RST;
    logic [1:0] vinfo_i;
    logic       nDSYNC;
    logic [3:0] Sync_o;
    logic       field_o;
    logic [1:0] vinfo_o;

    logic       big_nd;
    logic [3:0] big_sync;
    logic       big_field;
    logic [1:0] big_vinfo;

    int checks   = 0;
    int failures = 0;

    n64_sync_gen #(
        .H_TOTAL_NTSC(HN), .H_TOTAL_PAL(HP), .HSYNC_LEN(HS), .CLAMP_LEN(CL),
        .VSYNC_LINES(VS), .LH_NTSC(LHN), .LH_PAL(LHP)
    ) dut (
        .VCLK(VCLK), .RST(RST), .vinfo_i(vinfo_i), .nDSYNC(nDSYNC),
        .Sync_o(Sync_o), .field_o(field_o), .vinfo_o(vinfo_o)
    );

    n64_sync_gen dut_full (
        .VCLK(VCLK), .RST(RST), .vinfo_i(2'b00), .nDSYNC(big_nd),
        .Sync_o(big_sync), .field_o(big_field), .vinfo_o(big_vinfo)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    // Reference: linear tick position within the frame, sync levels from plain window arithmetic.
    function automatic int h_of(logic [1:0] md);
        return md[1] ? HP : HN;
    endfunction

    function automatic int lh_of(logic [1:0] md);
        return md[1] ? LHP : LHN;
    endfunction

    function automatic int frame_len(logic [1:0] md);
        return (md[0] ? 2 * lh_of(md) + 1 : lh_of(md) + 1) * h_of(md);
    endfunction

    function automatic logic [3:0] exp_sync(int pos, logic [1:0] md);
        int  ht, hb, hpos;
        bit  vlow, hlow, clow;
        ht   = h_of(md);
        hb   = lh_of(md) * ht + ht / 2;
        hpos = pos % ht;
        vlow = (pos < VS * ht) || (md[0] && pos >= hb && pos < hb + VS * ht);
        hlow = hpos < HS;
        clow = !vlow && hpos >= HS && hpos < HS + CL;
        return {!vlow, !clow, !hlow, (hlow == vlow)};
    endfunction

    int         m_cnt;
    int         m_pos;
    logic [1:0] e_mode;
    logic       e_nd;
    logic [3:0] e_sync;
    logic       e_field;

    always @(posedge VCLK) begin
        if (RST) begin
            m_cnt   = 0;
            m_pos   = 0;
            e_mode  = vinfo_i;
            e_nd    = 1'b1;
            e_sync  = 4'b1111;
            e_field = 1'b0;
        end else begin
            m_cnt = m_cnt + 1;
            e_nd  = (m_cnt % 4) != 0;
            if ((m_cnt % 4) == 0) begin
                e_sync = exp_sync(m_pos, e_mode);
                if (m_pos == 0)
                    e_field = 1'b0;
                else if (e_mode[0] && m_pos == lh_of(e_mode) * h_of(e_mode) + h_of(e_mode) / 2)
                    e_field = 1'b1;
                m_pos = m_pos + 1;
                if (m_pos == frame_len(e_mode)) begin
                    m_pos  = 0;
                    e_mode = vinfo_i;
                end
            end
        end
    end

    task automatic test_reset();
        int first_low;
        logic [3:0] first_sync;
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge VCLK);
            if (i > 0) begin
                checks++;
                if ({nDSYNC, Sync_o, field_o, vinfo_o} !== {1'b1, 4'b1111, 1'b0, vinfo_i}) begin
                    failures++;
                    $display("FAIL reset_state got=%b required=%b", {nDSYNC, Sync_o, field_o, vinfo_o},
                             {1'b1, 4'b1111, 1'b0, vinfo_i});
                end
            end
            vinfo_i = (i == 9) ? 2'b00 : 2'($urandom_range(0, 3));
        end
        @(negedge VCLK);
        RST = 1'b0;
        first_low  = 0;
        first_sync = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge VCLK);
            checks++;
            if ({nDSYNC, Sync_o, field_o, vinfo_o} !== {e_nd, e_sync, e_field, e_mode}) begin
                failures++;
                $display("FAIL start_model cyc=%0d got=%b required=%b", k,
                         {nDSYNC, Sync_o, field_o, vinfo_o}, {e_nd, e_sync, e_field, e_mode});
            end
            if (nDSYNC === 1'b0 && first_low == 0) begin
                first_low  = k;
                first_sync = Sync_o;
            end
        end
        checks++;
        if (first_low !== 4) begin
            failures++;
            $display("FAIL first_ndsync got=%0d required=4", first_low);
        end
        checks++;
        if (first_sync !== 4'b0101) begin
            failures++;
            $display("FAIL first_tick_sync got=%b required=0101", first_sync);
        end
    endtask

    task automatic test_defaults();
        int t, hlow_first, vlow_cnt, clamp_cnt, second_fall, falls;
        logic prev_h;
        RST = 1'b1;
        repeat (3) @(negedge VCLK);
        RST = 1'b0;
        t = 0; hlow_first = 0; vlow_cnt = 0; clamp_cnt = 0; second_fall = -1; falls = 0;
        prev_h = 1'b1;
        for (int c = 0; c < 4 * 3100 + 8 && t < 3100; c++) begin
            @(negedge VCLK);
            if (big_nd === 1'b0) begin
                if (prev_h === 1'b1 && big_sync[1] === 1'b0) begin
                    falls++;
                    if (falls == 2) second_fall = t;
                end
                prev_h = big_sync[1];
                if (t < 773 && big_sync[1] === 1'b0) hlow_first++;
                if (big_sync[3] === 1'b0) vlow_cnt++;
                if (big_sync[2] === 1'b0) clamp_cnt++;
                t++;
            end
        end
        checks++;
        if (t !== 3100) begin
            failures++;
            $display("FAIL full_tick_budget got=%0d required=3100", t);
        end
        checks++;
        if (second_fall !== 773) begin
            failures++;
            $display("FAIL full_line_len got=%0d required=773", second_fall);
        end
        checks++;
        if (hlow_first !== 57) begin
            failures++;
            $display("FAIL full_hsync_len got=%0d required=57", hlow_first);
        end
        checks++;
        if (vlow_cnt !== 3 * 773) begin
            failures++;
            $display("FAIL full_vsync_len got=%0d required=%0d", vlow_cnt, 3 * 773);
        end
        checks++;
        if (clamp_cnt !== 20) begin
            failures++;
            $display("FAIL full_clamp_len got=%0d required=20", clamp_cnt);
        end
    endtask

    task automatic test_progressive();
        int t, nf;
        int f[4];
        logic prev_v;
        vinfo_i = 2'b00;
        RST = 1'b1;
        repeat (2) @(negedge VCLK);
        RST = 1'b0;
        t = 0; nf = 0; prev_v = 1'b1;
        for (int c = 0; c < 4 * (2 * (LHN + 1) * HN + 10) && failures < 50; c++) begin
            @(negedge VCLK);
            checks++;
            if ({nDSYNC, Sync_o, field_o, vinfo_o} !== {e_nd, e_sync, e_field, e_mode}) begin
                failures++;
                $display("FAIL prog cyc=%0d got=%b required=%b", c,
                         {nDSYNC, Sync_o, field_o, vinfo_o}, {e_nd, e_sync, e_field, e_mode});
            end
            if (nDSYNC === 1'b0) begin
                if (prev_v === 1'b1 && Sync_o[3] === 1'b0 && nf < 4) begin
                    f[nf] = t;
                    nf++;
                end
                prev_v = Sync_o[3];
                t++;
            end
        end
        checks++;
        if (nf < 2 || f[1] - f[0] !== (LHN + 1) * HN) begin
            failures++;
            $display("FAIL prog_vsync_period falls=%0d got=%0d required=%0d", nf,
                     (nf < 2) ? -1 : f[1] - f[0], (LHN + 1) * HN);
        end
    endtask

    task automatic test_interlaced();
        int t, nf;
        int f[4];
        logic prev_v;
        vinfo_i = 2'b01;
        RST = 1'b1;
        repeat (2) @(negedge VCLK);
        RST = 1'b0;
        t = 0; nf = 0; prev_v = 1'b1;
        for (int c = 0; c < 4 * (2 * (2 * LHN + 1) * HN + 10) && failures < 50; c++) begin
            @(negedge VCLK);
            checks++;
            if ({nDSYNC, Sync_o, field_o, vinfo_o} !== {e_nd, e_sync, e_field, e_mode}) begin
                failures++;
                $display("FAIL intl cyc=%0d got=%b required=%b", c,
                         {nDSYNC, Sync_o, field_o, vinfo_o}, {e_nd, e_sync, e_field, e_mode});
            end
            if (nDSYNC === 1'b0) begin
                if (prev_v === 1'b1 && Sync_o[3] === 1'b0 && nf < 4) begin
                    f[nf] = t;
                    nf++;
                end
                prev_v = Sync_o[3];
                t++;
            end
        end
        checks++;
        if (nf < 3 || f[1] - f[0] !== LHN * HN + HN / 2 || f[2] - f[1] !== (LHN + 1) * HN - HN / 2) begin
            failures++;
            $display("FAIL intl_field_len falls=%0d got=%0d,%0d required=%0d,%0d", nf,
                     (nf < 2) ? -1 : f[1] - f[0], (nf < 3) ? -1 : f[2] - f[1],
                     LHN * HN + HN / 2, (LHN + 1) * HN - HN / 2);
        end
    endtask

    task automatic test_mode_change();
        int sw;
        vinfo_i = 2'b00;
        RST = 1'b1;
        repeat (2) @(negedge VCLK);
        RST = 1'b0;
        sw = 4 * $urandom_range(20, (LHN + 1) * HN - 20);
        for (int c = 0; c < 4 * ((LHN + 1) * HN + (LHP + 1) * HP + 10) && failures < 50; c++) begin
            @(negedge VCLK);
            checks++;
            if ({nDSYNC, Sync_o, field_o, vinfo_o} !== {e_nd, e_sync, e_field, e_mode}) begin
                failures++;
                $display("FAIL mode_change cyc=%0d got=%b required=%b", c,
                         {nDSYNC, Sync_o, field_o, vinfo_o}, {e_nd, e_sync, e_field, e_mode});
            end
            if (c == sw) vinfo_i = 2'b10;
        end
    endtask

    task automatic test_random();
        vinfo_i = 2'($urandom_range(0, 3));
        RST = 1'b1;
        repeat (2) @(negedge VCLK);
        RST = 1'b0;
        for (int c = 0; c < 9000 && failures < 50; c++) begin
            @(negedge VCLK);
            checks++;
            if ({nDSYNC, Sync_o, field_o, vinfo_o} !== {e_nd, e_sync, e_field, e_mode}) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b required=%b", c,
                         {nDSYNC, Sync_o, field_o, vinfo_o}, {e_nd, e_sync, e_field, e_mode});
            end
            if ($urandom_range(0, 299) == 0) vinfo_i = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        vinfo_i = 2'b01;
        RST = 1'b1;
        repeat (2) @(negedge VCLK);
        RST = 1'b0;
        repeat (4 * (5 * HN) + 2) @(negedge VCLK);
        vinfo_i = 2'b11;
        RST = 1'b1;
        @(negedge VCLK);
        RST = 1'b0;
        checks++;
        if ({nDSYNC, Sync_o, field_o, vinfo_o} !== {1'b1, 4'b1111, 1'b0, 2'b11}) begin
            failures++;
            $display("FAIL mid_reset got=%b required=%b", {nDSYNC, Sync_o, field_o, vinfo_o},
                     {1'b1, 4'b1111, 1'b0, 2'b11});
        end
        for (int c = 0; c < 4 * 60 && failures < 50; c++) begin
            @(negedge VCLK);
            checks++;
            if ({nDSYNC, Sync_o, field_o, vinfo_o} !== {e_nd, e_sync, e_field, e_mode}) begin
                failures++;
                $display("FAIL after_mid_reset cyc=%0d got=%b required=%b", c,
                         {nDSYNC, Sync_o, field_o, vinfo_o}, {e_nd, e_sync, e_field, e_mode});
            end
        end
    endtask

    initial begin
        RST     = 1'b1;
        vinfo_i = 2'b00;
        test_reset();
        test_defaults();
        test_progressive();
        test_interlaced();
        test_mode_change();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
